spi_byte_queue: RTL and testbench

// - Buffered byte front-end directly upstream of SPI_Master. Accepts TX bytes via valid/ready,

---
 rtl/spi_byte_queue_if.sv | 25 ++
 rtl/spi_byte_queue.sv | 165 ++++++++++++++++
 tb/tb_spi_byte_queue.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_queue_if
// Brief    : Host-side TX/RX byte stream bundle for spi_byte_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_byte_queue_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_byte_queue.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_queue
// Brief    : TX/RX byte FIFOs in front of an SPI master, one transfer in flight.
//            Optional watchdog on the master's done enabled by SPI_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_queue #(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic              clk,
    input  wire logic              rst,
    spi_byte_queue_if.slave        host,
    output logic                   spi_send,
    output logic [7:0]             spi_data_in,
    input  wire logic [7:0]        spi_data_out,
    input  wire logic              spi_done,
    output logic                   busy,
    output logic [ADDR_W:0]        tx_level,
    output logic [ADDR_W:0]        rx_level,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   c_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);
    localparam int                c_GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam state_t            c_AFTER_XFER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t              r_state;
    logic [7:0]          r_tx_mem [DEPTH];
    logic [7:0]          r_rx_mem [DEPTH];
    logic [ADDR_W-1:0]   r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [ADDR_W:0]     r_tx_level, r_rx_level;
    logic                r_done_q;
    logic                r_spi_send;
    logic [7:0]          r_spi_data_in;
    logic [c_GAP_W-1:0]  r_gap_cnt;

    logic w_tx_ready, w_rx_valid;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_done_rise;

    assign w_done_rise = spi_done & ~r_done_q;
    assign w_tx_ready  = (r_tx_level != c_FULL);
    assign w_rx_valid  = (r_rx_level != '0);
    assign w_tx_push   = host.tx_valid & w_tx_ready;
    // Launch only with room in RX, so a completed transfer can always be stored.
    assign w_tx_pop    = (r_state == S_IDLE) && (r_tx_level != '0) && (r_rx_level != c_FULL);
    assign w_rx_push   = (r_state == S_WAIT_DONE) && w_done_rise;
    assign w_rx_pop    = host.rx_ready & w_rx_valid;

    assign host.tx_ready = w_tx_ready;
    assign host.rx_valid = w_rx_valid;
    assign host.rx_data  = r_rx_mem[r_rx_rd];
    assign tx_level      = r_tx_level;
    assign rx_level      = r_rx_level;
    assign spi_send      = r_spi_send;
    assign spi_data_in   = r_spi_data_in;
    assign busy          = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= host.tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= spi_data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_level <= '0;
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
            if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + c_LVL_ONE;
            else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - c_LVL_ONE;

            if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
            if (w_rx_push && !w_rx_pop)      r_rx_level <= r_rx_level + c_LVL_ONE;
            else if (!w_rx_push && w_rx_pop) r_rx_level <= r_rx_level - c_LVL_ONE;
        end
    end

`ifdef SPI_TIMEOUT_EN
    localparam int               c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_done_q      <= 1'b0;
            r_spi_send    <= 1'b0;
            r_spi_data_in <= 8'h00;
            r_gap_cnt     <= '0;
`ifdef SPI_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_done_q   <= spi_done;
            r_spi_send <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tx_pop) begin
                        r_spi_data_in <= r_tx_mem[r_tx_rd];
                        r_spi_send    <= 1'b1;
                        r_state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef SPI_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    r_gap_cnt <= '0;
                    if (w_done_rise) begin
                        r_state <= c_AFTER_XFER;
`ifdef SPI_TIMEOUT_EN
                    end else if (r_to_cnt == c_TO_LAST) begin
                        // Abandon the transfer: nothing is queued for readback.
                        r_timeout_err <= 1'b1;
                        r_state       <= c_AFTER_XFER;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
`endif
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) r_state <= S_IDLE;
                    else                         r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_byte_queue
// Brief    : Scoreboard bench for spi_byte_queue; the SPI side returns data_in+1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_byte_queue;
`ifdef SPI_TIMEOUT_EN
    localparam int c_TIMEOUT = 16;
`else
    localparam int c_TIMEOUT = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_send;
    logic [7:0] spi_data_in;
    logic [7:0] spi_data_out = 8'h00;
    logic       spi_done;
    logic       resp_done = 1'b0;
    logic       force_done = 1'b0;
    logic       busy;
    logic [3:0] tx_level, rx_level;
    logic       timeout_err;

    spi_byte_queue_if host_if ();

    assign spi_done = resp_done | force_done;

    spi_byte_queue #(
        .DEPTH(8), .ADDR_W(3), .GAP_CYCLES(2), .TIMEOUT_CYCLES(c_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .host(host_if.slave),
        .spi_send(spi_send), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_done(spi_done),
        .busy(busy), .tx_level(tx_level), .rx_level(rx_level),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_sends  = 0;
    bit         resp_en  = 1'b0;
    logic       prev_send = 1'b0;
    logic [7:0] resp_d;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc_pos();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b, input int max_wait, output bit accepted);
        cyc_pos();
        accepted = 1'b0;
        host_if.tx_valid = 1'b1;
        host_if.tx_data  = b;
        for (int i = 0; i < max_wait && !accepted; i++) begin
            @(negedge clk);
            accepted = host_if.tx_ready;
            @(posedge clk); #1;
        end
        host_if.tx_valid = 1'b0;
    endtask

    task automatic expect_xfer(input logic [7:0] b, input bit with_rx);
        exp_tx.push_back(b);
        if (with_rx) exp_rx.push_back(b + 8'h01);
    endtask

    task automatic do_reset();
        cyc_pos();
        rst = 1'b1;
        repeat (2) cyc_pos();
        exp_tx.delete();
        exp_rx.delete();
        rst = 1'b0;
    endtask

    // Send monitor: each launch must be one cycle wide and carry the next queued byte.
    initial forever begin
        @(negedge clk);
        if (!rst && spi_send === 1'b1) begin
            n_sends++;
            check("send_pulse_width", int'(prev_send), 0);
            if (exp_tx.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL send_unexpected: got data 0x%0h expected no launch", spi_data_in);
            end else begin
                check("send_data", int'(spi_data_in), int'(exp_tx.pop_front()));
            end
        end
        prev_send = spi_send;
    end

    // RX monitor: every host pop is compared against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst && host_if.rx_valid === 1'b1 && host_if.rx_ready === 1'b1) begin
            if (exp_rx.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rx_unexpected: got 0x%0h expected no data", host_if.rx_data);
            end else begin
                check("rx_data", int'(host_if.rx_data), int'(exp_rx.pop_front()));
            end
        end
    end

    // SPI-side responder: done pulse three cycles after launch, data = data_in + 1.
    initial forever begin
        @(negedge clk);
        if (spi_send === 1'b1 && resp_en) begin
            resp_d = spi_data_in;
            repeat (3) @(posedge clk);
            #1;
            spi_data_out = resp_d + 8'h01;
            resp_done    = 1'b1;
            @(posedge clk); #1;
            resp_done    = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int base;
        int n_acc;
        host_if.tx_valid = 1'b0;
        host_if.tx_data  = 8'h00;
        host_if.rx_ready = 1'b0;

        // Reset state
        do_reset();
        tick();
        check("rst_tx_ready", int'(host_if.tx_ready), 1);
        check("rst_rx_valid", int'(host_if.rx_valid), 0);
        check("rst_spi_send", int'(spi_send), 0);
        check("rst_data_in", int'(spi_data_in), 8'h00);
        check("rst_tx_level", int'(tx_level), 0);
        check("rst_rx_level", int'(rx_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(timeout_err), 0);

        // Single byte: A5 out, A6 back; launch two cycles after the handshake
        resp_en = 1'b1;
        expect_xfer(8'hA5, 1'b1);
        push(8'hA5, 10, acc);
        check("single_accept", int'(acc), 1);
        tick();
        check("lat_n1_send", int'(spi_send), 0);
        tick();
        check("lat_n2_send", int'(spi_send), 1);
        check("lat_n2_data", int'(spi_data_in), 8'hA5);
        tick();
        check("lat_n3_send", int'(spi_send), 0);
        check("xfer_busy", int'(busy), 1);
        for (int i = 0; i < 50 && !host_if.rx_valid; i++) tick();
        check("single_rx_valid", int'(host_if.rx_valid), 1);
        check("single_rx_level", int'(rx_level), 1);
        check("single_rx_head", int'(host_if.rx_data), 8'hA6);
        check("single_hold_data", int'(spi_data_in), 8'hA5);
        cyc_pos(); host_if.rx_ready = 1'b1;
        cyc_pos(); host_if.rx_ready = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("single_idle", int'(busy), 0);
        check("single_rx_empty", int'(rx_level), 0);

        // Backpressure: RX fills after eight transfers and launches stop
        base = n_sends;
        for (int b = 1; b <= 10; b++) begin
            expect_xfer(8'(b), 1'b1);
            push(8'(b), 200, acc);
            check("bp_accept", int'(acc), 1);
        end
        for (int i = 0; i < 400 && rx_level != 4'd8; i++) tick();
        repeat (30) tick();
        check("bp_sends", n_sends - base, 8);
        check("bp_rx_level", int'(rx_level), 8);
        check("bp_tx_level", int'(tx_level), 2);
        check("bp_busy", int'(busy), 0);
        check("bp_tx_ready", int'(host_if.tx_ready), 1);
        cyc_pos(); host_if.rx_ready = 1'b1;
        cyc_pos(); host_if.rx_ready = 1'b0;
        for (int i = 0; i < 20 && (n_sends - base) != 9; i++) tick();
        check("bp_ninth_send", n_sends - base, 9);
        for (int i = 0; i < 40 && (busy || rx_level != 4'd8); i++) tick();
        check("bp_refill_rx", int'(rx_level), 8);
        check("bp_refill_tx", int'(tx_level), 1);
        cyc_pos(); host_if.rx_ready = 1'b1;
        for (int i = 0; i < 400 && (rx_level != 0 || tx_level != 0 || busy); i++) tick();
        cyc_pos(); host_if.rx_ready = 1'b0;
        check("bp_drained_rx", int'(rx_level), 0);
        check("bp_drained_tx", int'(tx_level), 0);
        check("bp_sends_total", n_sends - base, 10);
        check("bp_exp_rx_left", exp_rx.size(), 0);

        // TX full: done never arrives, first byte launched, eight stored, tenth dropped
        resp_en = 1'b0;
        n_acc = 0;
        expect_xfer(8'h31, 1'b0);
        for (int b = 0; b < 10; b++) begin
            push(8'h31 + 8'(b), 4, acc);
            if (acc) n_acc++;
            if (b == 9) check("full_tenth_dropped", int'(acc), 0);
        end
        check("full_accepted", n_acc, 9);
        tick();
        check("full_tx_ready", int'(host_if.tx_ready), 0);
        check("full_tx_level", int'(tx_level), 8);
        check("full_busy", int'(busy), 1);
        check("full_rx_level", int'(rx_level), 0);
        do_reset();

        // Reset mid-transfer with three queued; done arriving under reset is ignored
        expect_xfer(8'h41, 1'b0);
        for (int b = 0; b < 3; b++) push(8'h41 + 8'(b), 10, acc);
        repeat (5) tick();
        check("mid_busy", int'(busy), 1);
        check("mid_tx_level", int'(tx_level), 2);
        cyc_pos();
        rst = 1'b1;
        force_done = 1'b1;
        spi_data_out = 8'hEE;
        repeat (2) cyc_pos();
        exp_tx.delete();
        exp_rx.delete();
        rst = 1'b0;
        force_done = 1'b0;
        tick();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_tx_level", int'(tx_level), 0);
        check("mid_rst_rx_level", int'(rx_level), 0);
        check("mid_rst_rx_valid", int'(host_if.rx_valid), 0);
        check("mid_rst_data_in", int'(spi_data_in), 8'h00);
        check("mid_rst_tx_ready", int'(host_if.tx_ready), 1);
        resp_en = 1'b1;
        expect_xfer(8'h50, 1'b1);
        push(8'h50, 10, acc);
        tick(); tick();
        check("mid_after_send", int'(spi_send), 1);
        for (int i = 0; i < 50 && !host_if.rx_valid; i++) tick();
        check("mid_after_rx_level", int'(rx_level), 1);
        cyc_pos(); host_if.rx_ready = 1'b1;
        cyc_pos(); host_if.rx_ready = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("mid_after_exp_left", exp_rx.size(), 0);

`ifdef SPI_TIMEOUT_EN
        // Watchdog: 16 WAIT_DONE cycles without done, then the next byte after the gap
        resp_en = 1'b0;
        base = n_sends;
        expect_xfer(8'h11, 1'b0);
        expect_xfer(8'h22, 1'b0);
        push(8'h11, 10, acc);
        push(8'h22, 10, acc);
        for (int i = 0; i < 20 && n_sends == base; i++) tick();
        check("to_first_send", n_sends - base, 1);
        repeat (16) tick();
        check("to_not_yet", int'(timeout_err), 0);
        tick();
        check("to_set", int'(timeout_err), 1);
        check("to_rx_level", int'(rx_level), 0);
        for (int i = 0; i < 10 && (n_sends - base) != 2; i++) tick();
        check("to_second_send", n_sends - base, 2);
        repeat (40) tick();
        check("to_sticky", int'(timeout_err), 1);
        check("to_rx_still_empty", int'(rx_level), 0);
        do_reset();
        tick();
        check("to_rst_clear", int'(timeout_err), 0);
`endif

        check("end_exp_tx_left", exp_tx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
